// File: rtl/eee_msg_reader.sv
// eee_msg_reader: Avalon-MM master that polls the image block's message FIFO,
// parses 3-word red-bounding-box messages and presents each one as a valid/ready record.
module eee_msg_reader #(
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter logic [31:0] MSG_ID        = 32'h0052_4242,
  parameter int unsigned MSG_WORDS     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        m_chipselect,
  output logic        m_read,
  output logic [2:0]  m_address,
  input  logic [31:0] m_readdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_found,
  output logic [10:0] out_x_min,
  output logic [10:0] out_x_max,
  output logic [7:0]  out_seq,
  output logic [7:0]  err_count
);

  localparam int unsigned        TIMER_W      = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_INTERVAL - 1);
  localparam logic [7:0]         AVAIL_MIN    = 8'(MSG_WORDS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_STAT_RD   = 3'd1,
    S_STAT_WAIT = 3'd2,
    S_WORD_RD   = 3'd3,
    S_WORD_WAIT = 3'd4,
    S_GAP       = 3'd5,
    S_OUT       = 3'd6
  } state_t;

  state_t             r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [7:0]         r_avail;
  logic [1:0]         r_idx;
  logic               r_gap_to_word;
  logic [10:0]        r_x_min;
  logic [10:0]        r_x_max;
  logic               r_cs;
  logic               r_read;
  logic [2:0]         r_addr;
  logic               r_valid;
  logic               r_found;
  logic [10:0]        r_out_x_min;
  logic [10:0]        r_out_x_max;
  logic [7:0]         r_seq;
  logic [7:0]         r_err;

  logic [7:0] w_avail;
  logic       w_coord_bad;

  assign w_avail     = m_readdata[15:8];
  assign w_coord_bad = (m_readdata[31:27] != 5'd0) || (m_readdata[15:11] != 5'd0);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Poll/parse FSM; bus strobes are registered on entry to the two read states.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_timer       <= TIMER_RELOAD;
      r_avail       <= 8'd0;
      r_idx         <= 2'd0;
      r_gap_to_word <= 1'b0;
      r_x_min       <= 11'd0;
      r_x_max       <= 11'd0;
      r_cs          <= 1'b0;
      r_read        <= 1'b0;
      r_addr        <= 3'd0;
      r_valid       <= 1'b0;
      r_found       <= 1'b0;
      r_out_x_min   <= 11'd0;
      r_out_x_max   <= 11'd0;
      r_seq         <= 8'd0;
      r_err         <= 8'd0;
    end else begin
      r_cs   <= 1'b0;
      r_read <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_timer != {TIMER_W{1'b0}}) begin
            r_timer <= r_timer - 1'b1;
          end else if (enable) begin
            r_state <= S_STAT_RD;
            r_cs    <= 1'b1;
            r_read  <= 1'b1;
            r_addr  <= 3'd0;
          end else begin
            r_timer <= r_timer;
          end
        end
        S_STAT_RD: begin
          r_state <= S_STAT_WAIT;
        end
        S_STAT_WAIT: begin
          r_avail <= w_avail;
          if (w_avail >= AVAIL_MIN) begin
            r_idx         <= 2'd0;
            r_gap_to_word <= 1'b1;
            r_state       <= S_GAP;
          end else begin
            r_timer <= TIMER_RELOAD;
            r_state <= S_IDLE;
          end
        end
        S_WORD_RD: begin
          r_state <= S_WORD_WAIT;
        end
        S_WORD_WAIT: begin
          r_avail <= (r_avail != 8'd0) ? r_avail - 8'd1 : 8'd0;
          // Any parse error drops the message and resyncs through a fresh status read.
          case (r_idx)
            2'd0: begin
              r_state <= S_GAP;
              if (m_readdata != MSG_ID) begin
                r_err         <= sat_inc(r_err);
                r_gap_to_word <= 1'b0;
              end else begin
                r_idx         <= 2'd1;
                r_gap_to_word <= 1'b1;
              end
            end
            2'd1: begin
              r_x_min <= m_readdata[26:16];
              r_x_max <= m_readdata[10:0];
              r_state <= S_GAP;
              if (w_coord_bad) begin
                r_err         <= sat_inc(r_err);
                r_gap_to_word <= 1'b0;
              end else begin
                r_idx         <= 2'd2;
                r_gap_to_word <= 1'b1;
              end
            end
            2'd2: begin
              if (m_readdata != 32'd0) begin
                r_err         <= sat_inc(r_err);
                r_gap_to_word <= 1'b0;
                r_state       <= S_GAP;
              end else begin
                r_valid     <= 1'b1;
                r_found     <= (r_x_min <= r_x_max);
                r_out_x_min <= r_x_min;
                r_out_x_max <= r_x_max;
                r_state     <= S_OUT;
              end
            end
            default: begin
              r_idx         <= 2'd0;
              r_gap_to_word <= 1'b0;
              r_state       <= S_GAP;
            end
          endcase
        end
        S_GAP: begin
          r_cs   <= 1'b1;
          r_read <= 1'b1;
          if (r_gap_to_word) begin
            r_state <= S_WORD_RD;
            r_addr  <= 3'd1;
          end else begin
            r_state <= S_STAT_RD;
            r_addr  <= 3'd0;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_seq   <= r_seq + 8'd1;
            r_state <= S_STAT_RD;
            r_cs    <= 1'b1;
            r_read  <= 1'b1;
            r_addr  <= 3'd0;
          end else begin
            r_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_timer <= TIMER_RELOAD;
          r_idx   <= 2'd0;
        end
      endcase
    end
  end

  assign m_chipselect = r_cs;
  assign m_read       = r_read;
  assign m_address    = r_addr;
  assign out_valid    = r_valid;
  assign out_found    = r_found;
  assign out_x_min    = r_out_x_min;
  assign out_x_max    = r_out_x_max;
  assign out_seq      = r_seq;
  assign err_count    = r_err;

endmodule

// File: tb/tb_eee_msg_reader.sv
// Bench for eee_msg_reader: FIFO slave model, stream-level parse model and a
// per-cycle compare process, driven by directed message scenarios.
module tb_eee_msg_reader;

  localparam int unsigned POLL = 1024;
  localparam logic [31:0] ID   = 32'h0052_4242;

  typedef struct packed {
    logic        found;
    logic [10:0] xmin;
    logic [10:0] xmax;
    logic [7:0]  seq;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset_n, enable, out_ready;
  logic        m_chipselect, m_read;
  logic [2:0]  m_address;
  logic [31:0] m_readdata = 32'd0;
  logic        out_valid, out_found;
  logic [10:0] out_x_min, out_x_max;
  logic [7:0]  out_seq, err_count;

  eee_msg_reader dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .m_chipselect(m_chipselect), .m_read(m_read), .m_address(m_address),
    .m_readdata(m_readdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_found(out_found), .out_x_min(out_x_min), .out_x_max(out_x_max),
    .out_seq(out_seq), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Slave: message FIFO that pops only on a rising read strobe.
  logic [31:0] fifo_q[$];
  logic        slv_prev_rd = 1'b0;
  always @(posedge clk) begin
    slv_prev_rd <= m_read;
    if (m_chipselect && m_read && !slv_prev_rd) begin
      if (m_address == 3'd0)
        m_readdata <= {16'd0, (fifo_q.size() > 255) ? 8'd255 : 8'(fifo_q.size()), 8'd0};
      else if (fifo_q.size() > 0)
        m_readdata <= fifo_q.pop_front();
      else
        m_readdata <= 32'd0;
    end
  end

  // Model: consume whole messages from the word stream by the parse rules.
  logic [31:0] mdl_q[$];
  rec_t        exp_q[$];
  int          exp_seq = 0;
  int          exp_err = 0;

  task automatic model_run();
    logic [31:0] w0, w1, w2;
    int xmin, xmax;
    while (mdl_q.size() >= 3) begin
      w0 = mdl_q[0]; w1 = mdl_q[1]; w2 = mdl_q[2];
      if (w0 != ID) begin
        exp_err++;
        void'(mdl_q.pop_front());
      end else if (w1[31:27] != 5'd0 || w1[15:11] != 5'd0) begin
        exp_err++;
        repeat (2) void'(mdl_q.pop_front());
      end else if (w2 != 32'd0) begin
        exp_err++;
        repeat (3) void'(mdl_q.pop_front());
      end else begin
        xmin = int'(w1[26:16]);
        xmax = int'(w1[10:0]);
        exp_q.push_back({(xmin <= xmax) ? 1'b1 : 1'b0, 11'(xmin), 11'(xmax), 8'(exp_seq)});
        exp_seq = (exp_seq + 1) % 256;
        repeat (3) void'(mdl_q.pop_front());
      end
    end
  endtask

  function automatic logic [31:0] pack(input int xmin, input int xmax);
    return {5'd0, 11'(xmin), 5'd0, 11'(xmax)};
  endfunction

  task automatic send(input logic [31:0] w, input bit to_model);
    fifo_q.push_back(w);
    if (to_model) mdl_q.push_back(w);
  endtask

  // Compare process: bus protocol and record contents on every falling edge.
  int   cyc = 0;
  int   last_read_cyc = -100;
  int   stat_count = 0, rd1_count = 0;
  int   last_stat_cyc = 0, prev_stat_cyc = 0;
  int   lat = 0;
  logic prev_read = 1'b0, prev_valid = 1'b0;
  rec_t last_rec = '0;
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (m_read) begin
        check("cs_with_read", 64'(m_chipselect), 64'(1));
        if (prev_read) check("strobe_width", 64'(prev_read), 64'(0));
        else check("read_gap_ok", 64'(cyc - last_read_cyc >= 3), 64'(1));
        last_read_cyc = cyc;
        if (m_address == 3'd0) begin
          stat_count++;
          prev_stat_cyc = last_stat_cyc;
          last_stat_cyc = cyc;
        end else begin
          rd1_count++;
        end
      end else if (m_chipselect) begin
        check("cs_without_read", 64'(m_chipselect), 64'(0));
      end
      if (out_valid) begin
        if (!prev_valid) lat = cyc - last_stat_cyc;
        check("no_read_in_out", 64'(m_read), 64'(0));
        if (exp_q.size() == 0) begin
          check("unexpected_record", 64'(out_valid), 64'(0));
        end else begin
          check("record", 64'({out_found, out_x_min, out_x_max, out_seq}), 64'(exp_q[0]));
          if (out_ready) begin
            last_rec = {out_found, out_x_min, out_x_max, out_seq};
            void'(exp_q.pop_front());
          end
        end
      end
      prev_valid = out_valid;
    end else begin
      prev_valid = 1'b0;
    end
    prev_read = m_read;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      tick(1);
      k++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_found"}, 64'(out_found), 64'(0));
    check({tag, "_xmin"},  64'(out_x_min), 64'(0));
    check({tag, "_xmax"},  64'(out_x_max), 64'(0));
    check({tag, "_seq"},   64'(out_seq), 64'(0));
    check({tag, "_err"},   64'(err_count), 64'(0));
    check({tag, "_cs"},    64'(m_chipselect), 64'(0));
    check({tag, "_read"},  64'(m_read), 64'(0));
    check({tag, "_addr"},  64'(m_address), 64'(0));
  endtask

  function automatic int sat_err(input int e);
    return (e > 255) ? 255 : e;
  endfunction

  initial begin
    int r0, s0, k;
    reset_n = 1'b0; enable = 1'b0; out_ready = 1'b0;
    tick(3);
    check_zero("reset");
    reset_n = 1'b1; enable = 1'b1; out_ready = 1'b1;

    // Basic message, first-poll latency.
    send(ID, 1); send(pack(100, 300), 1); send(32'd0, 1);
    model_run();
    check("model_s1", 64'(exp_q[0]), 64'({1'b1, 11'd100, 11'd300, 8'd0}));
    wait_drain("s1", 1500);
    check("s1_latency", 64'(lat), 64'(11));
    check("s1_rec", 64'(last_rec), 64'({1'b1, 11'd100, 11'd300, 8'd0}));
    check("s1_err", 64'(err_count), 64'(0));

    // Empty frame.
    send(ID, 1); send(pack(639, 0), 1); send(32'd0, 1);
    model_run();
    wait_drain("s2", 1500);
    check("s2_rec", 64'(last_rec), 64'({1'b0, 11'd639, 11'd0, 8'd1}));

    // Junk word before a valid message.
    r0 = rd1_count;
    send(32'hDEAD_BEEF, 1); send(ID, 1); send(pack(50, 60), 1); send(32'd0, 1);
    model_run();
    check("model_s3_err", 64'(exp_err), 64'(1));
    wait_drain("s3", 1500);
    check("s3_reads", 64'(rd1_count - r0), 64'(4));
    check("s3_err", 64'(err_count), 64'(1));
    check("s3_rec", 64'(last_rec), 64'({1'b1, 11'd50, 11'd60, 8'd2}));

    // Back-pressure: two messages queued, consumer stalls 50 cycles.
    out_ready = 1'b0;
    send(ID, 1); send(pack(10, 20), 1); send(32'd0, 1);
    send(ID, 1); send(pack(30, 40), 1); send(32'd0, 1);
    model_run();
    k = 0;
    while (!out_valid && k < 1500) begin tick(1); k++; end
    check("s4_valid_seen", 64'(out_valid), 64'(1));
    r0 = rd1_count; s0 = stat_count;
    tick(50);
    check("s4_hold_valid", 64'(out_valid), 64'(1));
    check("s4_hold_no_rd", 64'(rd1_count - r0), 64'(0));
    check("s4_hold_no_stat", 64'(stat_count - s0), 64'(0));
    out_ready = 1'b1;
    wait_drain("s4", 100);
    check("s4_rec", 64'(last_rec), 64'({1'b1, 11'd30, 11'd40, 8'd4}));

    // Only two words available: no word reads, full poll interval.
    r0 = rd1_count; s0 = stat_count;
    send(ID, 1); send(pack(1, 2), 1);
    model_run();
    k = 0;
    while (stat_count < s0 + 2 && k < 2600) begin tick(1); k++; end
    check("s5_two_polls", 64'(stat_count >= s0 + 2), 64'(1));
    check("s5_interval", 64'(last_stat_cyc - prev_stat_cyc), 64'(POLL + 2));
    check("s5_no_word_rd", 64'(rd1_count - r0), 64'(0));
    send(32'd0, 1);
    model_run();
    wait_drain("s5", 1500);
    check("s5_rec", 64'(last_rec), 64'({1'b1, 11'd1, 11'd2, 8'd5}));
    check("s5_err", 64'(err_count), 64'(sat_err(exp_err)));

    // Reset during WORD_WAIT of idx 1.
    r0 = rd1_count;
    send(ID, 0); send(pack(5, 6), 0); send(32'd0, 0);
    k = 0;
    while (rd1_count < r0 + 2 && k < 1500) begin tick(1); k++; end
    check("s6_reached_idx1", 64'(rd1_count - r0), 64'(2));
    reset_n = 1'b0;
    tick(1);
    check_zero("s6_reset");
    reset_n = 1'b1;
    exp_err = 0; exp_seq = 0;
    mdl_q = fifo_q;

    // 300 parse errors (leftover trailer + 299 junk), then a good message.
    for (int i = 0; i < 299; i++) send(32'h1111_1111, 1);
    send(ID, 1); send(pack(7, 8), 1); send(32'd0, 1);
    model_run();
    check("model_s7_err", 64'(exp_err), 64'(300));
    wait_drain("s7", 4500);
    check("s7_err_sat", 64'(err_count), 64'(255));
    check("s7_rec", 64'(last_rec), 64'({1'b1, 11'd7, 11'd8, 8'd0}));

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
